// File: rtl/dsp_aw_w_order_ctrl_if.sv
// rtl/dsp_aw_w_order_ctrl_if.sv - AW/W ordering bundle between master port, AW path and W dispatcher
interface dsp_aw_w_order_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int SLV_ID_W   = 1,
    parameter int CNT_W      = 3
);
    logic [ADDR_WIDTH-1:0] m_AWADDR_i;
    logic                  m_AWVALID_i;
    logic                  aw_slv_ready_i;
    logic                  m_AWREADY_o;
    logic                  m_WVALID_i;
    logic                  m_WLAST_i;
    logic                  m_WREADY_i;
    logic [SLV_ID_W-1:0]   dsp_AW_slv_id_o;
    logic                  dsp_AW_disable_o;
    logic [CNT_W-1:0]      outst_cnt_o;

    modport slave (
        input  m_AWADDR_i, m_AWVALID_i, aw_slv_ready_i,
        input  m_WVALID_i, m_WLAST_i, m_WREADY_i,
        output m_AWREADY_o, dsp_AW_slv_id_o, dsp_AW_disable_o, outst_cnt_o
    );

    modport master (
        output m_AWADDR_i, m_AWVALID_i, aw_slv_ready_i,
        output m_WVALID_i, m_WLAST_i, m_WREADY_i,
        input  m_AWREADY_o, dsp_AW_slv_id_o, dsp_AW_disable_o, outst_cnt_o
    );
endinterface

// File: rtl/dsp_aw_w_order_ctrl.sv
// rtl/dsp_aw_w_order_ctrl.sv - outstanding-write FIFO steering W beats in AW acceptance order
module dsp_aw_w_order_ctrl #(
    parameter int SLV_AMT        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int SLV_ID_W       = $clog2(SLV_AMT),
    parameter int SLV_ID_MSB_IDX = 30,
    parameter int SLV_ID_LSB_IDX = 30,
    parameter int OUTST_DEPTH    = 4
) (
    input  logic                  ACLK_i,
    input  logic                  ARESET_i,
    dsp_aw_w_order_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SLV_ID_W-1:0] mem_q [OUTST_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [SLV_ID_W-1:0]   aw_slv_id;
    logic                  full, empty, aw_ready, aw_hs, w_last_hs;
    logic                  unused_awaddr_bits;

    assign awaddr             = bus.m_AWADDR_i;
    assign aw_slv_id          = awaddr[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
    assign unused_awaddr_bits = ^awaddr;

    // Flags come from the registered count only, so a same-cycle pop never reopens AWREADY.
    assign full      = (cnt_q == CNT_W'(OUTST_DEPTH));
    assign empty     = (cnt_q == '0);
    assign aw_ready  = bus.aw_slv_ready_i & ~full;
    assign aw_hs     = bus.m_AWVALID_i & aw_ready;
    assign w_last_hs = bus.m_WVALID_i & bus.m_WREADY_i & bus.m_WLAST_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (aw_hs) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_last_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({aw_hs, w_last_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUTST_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (aw_hs) begin
                mem_q[wr_ptr_q] <= aw_slv_id;
            end
        end
    end

    assign bus.m_AWREADY_o      = aw_ready;
    assign bus.dsp_AW_slv_id_o  = mem_q[rd_ptr_q];
    assign bus.dsp_AW_disable_o = empty;
    assign bus.outst_cnt_o      = cnt_q;
endmodule

// File: tb/tb_dsp_aw_w_order_ctrl.sv
// tb/tb_dsp_aw_w_order_ctrl.sv - directed bench for the AW/W ordering controller
module tb_dsp_aw_w_order_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_force = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dsp_aw_w_order_ctrl_if #(.ADDR_WIDTH(32), .SLV_ID_W(1), .CNT_W(3)) bus ();

    // Bench plays the W dispatcher: ready whenever the controller is enabled.
    assign bus.m_WREADY_i = wr_force | ~bus.dsp_AW_disable_o;

    dsp_aw_w_order_ctrl #(
        .SLV_AMT(2), .ADDR_WIDTH(32), .SLV_ID_MSB_IDX(30), .SLV_ID_LSB_IDX(30), .OUTST_DEPTH(4)
    ) dut (
        .ACLK_i   (clk),
        .ARESET_i (rst),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_set(input logic valid, input logic id);
        bus.m_AWVALID_i = valid;
        bus.m_AWADDR_i  = {1'b0, id, 30'h0000_1230};
    endtask

    task automatic send_w(input int len, input logic exp_id, input string tag);
        for (int i = 0; i < len; i++) begin
            bus.m_WVALID_i = 1'b1;
            bus.m_WLAST_i  = (i == len - 1);
            #1;
            check({tag, " id"}, 32'(bus.dsp_AW_slv_id_o), 32'(exp_id));
            check({tag, " dis"}, 32'(bus.dsp_AW_disable_o), 32'd0);
            cyc();
        end
        bus.m_WVALID_i = 1'b0;
        bus.m_WLAST_i  = 1'b0;
    endtask

    initial begin
        aw_set(1'b0, 1'b0);
        bus.aw_slv_ready_i = 1'b1;
        bus.m_WVALID_i     = 1'b0;
        bus.m_WLAST_i      = 1'b0;

        // reset then idle
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst dis", 32'(bus.dsp_AW_disable_o), 32'd1);
        check("rst cnt", 32'(bus.outst_cnt_o), 32'd0);
        check("rst awrdy", 32'(bus.m_AWREADY_o), 32'd1);
        bus.aw_slv_ready_i = 1'b0;
        aw_set(1'b1, 1'b1);
        #1;
        check("slv not ready awrdy", 32'(bus.m_AWREADY_o), 32'd0);
        cyc();
        check("slv not ready cnt", 32'(bus.outst_cnt_o), 32'd0);
        bus.aw_slv_ready_i = 1'b1;

        // single burst to slave 1; W beat alongside the AW must be refused
        bus.m_WVALID_i = 1'b1;
        #1;
        check("single awrdy", 32'(bus.m_AWREADY_o), 32'd1);
        check("same-cycle wrdy", 32'(bus.m_WREADY_i), 32'd0);
        cyc();
        aw_set(1'b0, 1'b0);
        bus.m_WVALID_i = 1'b0;
        #1;
        check("single c1 dis", 32'(bus.dsp_AW_disable_o), 32'd0);
        check("single c1 id", 32'(bus.dsp_AW_slv_id_o), 32'd1);
        check("single c1 cnt", 32'(bus.outst_cnt_o), 32'd1);
        send_w(4, 1'b1, "single");
        #1;
        check("single end dis", 32'(bus.dsp_AW_disable_o), 32'd1);
        check("single end cnt", 32'(bus.outst_cnt_o), 32'd0);

        // ordering: AWs 0,1,0 then bursts of 1,2,3 beats back to back
        aw_set(1'b1, 1'b0); cyc();
        aw_set(1'b1, 1'b1); cyc();
        aw_set(1'b1, 1'b0); cyc();
        aw_set(1'b0, 1'b0);
        #1;
        check("order cnt", 32'(bus.outst_cnt_o), 32'd3);
        send_w(1, 1'b0, "order b0");
        send_w(2, 1'b1, "order b1");
        send_w(3, 1'b0, "order b2");
        #1;
        check("order end cnt", 32'(bus.outst_cnt_o), 32'd0);

        // full: four accepts, fifth held until a pop has registered
        for (int i = 0; i < 4; i++) begin
            aw_set(1'b1, 1'(i % 2));
            #1;
            check("fill awrdy", 32'(bus.m_AWREADY_o), 32'd1);
            cyc();
        end
        aw_set(1'b1, 1'b0);
        #1;
        check("full cnt", 32'(bus.outst_cnt_o), 32'd4);
        check("full awrdy", 32'(bus.m_AWREADY_o), 32'd0);
        cyc();
        check("full held cnt", 32'(bus.outst_cnt_o), 32'd4);
        bus.m_WVALID_i = 1'b1;
        bus.m_WLAST_i  = 1'b1;
        #1;
        check("full pop awrdy", 32'(bus.m_AWREADY_o), 32'd0);
        cyc();
        bus.m_WVALID_i = 1'b0;
        bus.m_WLAST_i  = 1'b0;
        #1;
        check("after pop cnt", 32'(bus.outst_cnt_o), 32'd3);
        check("after pop awrdy", 32'(bus.m_AWREADY_o), 32'd1);
        cyc();
        aw_set(1'b0, 1'b0);
        #1;
        check("refill cnt", 32'(bus.outst_cnt_o), 32'd4);
        check("refill awrdy", 32'(bus.m_AWREADY_o), 32'd0);
        send_w(1, 1'b1, "drain0");
        send_w(1, 1'b0, "drain1");
        send_w(1, 1'b1, "drain2");
        send_w(1, 1'b0, "drain3");
        #1;
        check("drain cnt", 32'(bus.outst_cnt_o), 32'd0);

        // simultaneous push/pop at count 1, pointers wrap several times
        aw_set(1'b1, 1'b0); cyc();
        for (int k = 1; k <= 10; k++) begin
            aw_set(1'b1, 1'(k % 2));
            bus.m_WVALID_i = 1'b1;
            bus.m_WLAST_i  = 1'b1;
            #1;
            check("stream cnt", 32'(bus.outst_cnt_o), 32'd1);
            check("stream id", 32'(bus.dsp_AW_slv_id_o), 32'((k - 1) % 2));
            check("stream awrdy", 32'(bus.m_AWREADY_o), 32'd1);
            cyc();
        end
        aw_set(1'b0, 1'b0);
        bus.m_WVALID_i = 1'b0;
        bus.m_WLAST_i  = 1'b0;
        #1;
        check("stream end cnt", 32'(bus.outst_cnt_o), 32'd1);
        check("stream end id", 32'(bus.dsp_AW_slv_id_o), 32'd0);
        send_w(1, 1'b0, "stream drain");

        // reset with three outstanding bursts, first one mid-burst
        aw_set(1'b1, 1'b1); cyc();
        aw_set(1'b1, 1'b0); cyc();
        aw_set(1'b1, 1'b1); cyc();
        aw_set(1'b0, 1'b0);
        bus.m_WVALID_i = 1'b1;
        cyc();
        #1;
        check("pre-rst cnt", 32'(bus.outst_cnt_o), 32'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("post-rst cnt", 32'(bus.outst_cnt_o), 32'd0);
        check("post-rst dis", 32'(bus.dsp_AW_disable_o), 32'd1);
        check("post-rst wrdy", 32'(bus.m_WREADY_i), 32'd0);
        check("post-rst id", 32'(bus.dsp_AW_slv_id_o), 32'd0);
        // a stray WLAST handshake while empty must not underflow the count
        wr_force       = 1'b1;
        bus.m_WLAST_i  = 1'b1;
        cyc();
        wr_force       = 1'b0;
        bus.m_WVALID_i = 1'b0;
        bus.m_WLAST_i  = 1'b0;
        #1;
        check("empty guard cnt", 32'(bus.outst_cnt_o), 32'd0);
        check("empty guard dis", 32'(bus.dsp_AW_disable_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
